// File: rtl/demux_1x8_scheduler_if.sv
// ----------------------------------------------------------------------------
// demux_1x8_scheduler_if
//
// Bundle of the source stream, the per-destination flow-control lines and the
// demux-tree control outputs of the 1-to-8 burst scheduler.
//
// Handshake rule for every stream here: a word moves on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// A valid source holds its word stable until it is taken.
//
// Signals:
//   in_valid / in_data / in_ready : source stream into the scheduler
//   dest_en                       : per-destination enable mask (bit k = dest k)
//   dest_ready                    : per-destination ready
//   sel                           : demux select, ins1=sel[2] ins2=sel[1] ins3=sel[0]
//   out_valid                     : one-hot strobe towards destination sel
//   out_data                      : word presented to the demux input
//   burst_done                    : one-cycle pulse after a completed burst
//   beat_cnt                      : words sent in the current burst
//
// Modports:
//   master : the scheduler itself
//   slave  : the source / destination side facing the scheduler
// ----------------------------------------------------------------------------
interface demux_1x8_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
);
  localparam int CW = $clog2(BURST + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [7:0]       dest_en;
  logic [7:0]       dest_ready;
  logic [2:0]       sel;
  logic [7:0]       out_valid;
  logic [WIDTH-1:0] out_data;
  logic             burst_done;
  logic [CW-1:0]    beat_cnt;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    input  dest_en,
    input  dest_ready,
    output sel,
    output out_valid,
    output out_data,
    output burst_done,
    output beat_cnt
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    output dest_en,
    output dest_ready,
    input  sel,
    input  out_valid,
    input  out_data,
    input  burst_done,
    input  beat_cnt
  );
endinterface

// File: rtl/demux_1x8_scheduler.sv
// ----------------------------------------------------------------------------
// demux_1x8_scheduler
//
// Round-robin burst scheduler sharing one input word stream among eight
// destinations by driving the select lines of a combinational 1-to-8 demux
// tree. Each enabled destination gets a burst of up to BURST words, then
// ownership rotates to the next enabled destination.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : demux_1x8_scheduler_if.master (stream, flow control, demux ctl)
//   dbg_state : current FSM state (0 = IDLE, 1 = SEND)
//
// The WIDTH/BURST parameters must match those of the connected interface.
// ----------------------------------------------------------------------------
module demux_1x8_scheduler #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  demux_1x8_scheduler_if.master         bus,
  output logic                          dbg_state
);

  localparam int            CW   = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        state;
  logic [2:0]    sel_q;
  logic [CW-1:0] beat_q;
  logic          done_q;

  logic          cur_en;
  logic          ready_now;
  logic          xfer;

  // First index set in mask, searching upward from start and wrapping 7->0.
  // With skip_start set the search begins strictly after start, and start
  // itself is only chosen as the last resort (sole enabled destination).
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [2:0] pick_next(input logic [2:0] start,
                                           input logic [7:0] mask,
                                           input logic       skip_start);
    logic [2:0] idx;
    logic [2:0] res;
    res = start;
    for (int i = 8; i >= 0; i--) begin
      idx = start + 3'(i);
      if ((i != 0 || !skip_start) && mask[idx]) begin
        res = idx;
      end
    end
    return res;
  endfunction

  // Flow control: a word is only offered to the owner while it stays enabled
  // and ready, so clearing its enable bit drops in_ready in the same cycle.
  assign cur_en    = bus.dest_en[sel_q];
  assign ready_now = (state == S_SEND) && cur_en && bus.dest_ready[sel_q];
  assign xfer      = bus.in_valid && ready_now;

  assign bus.in_ready   = ready_now;
  assign bus.out_valid  = xfer ? (8'b0000_0001 << sel_q) : 8'b0;
  assign bus.out_data   = bus.in_data;
  assign bus.sel        = sel_q;
  assign bus.beat_cnt   = beat_q;
  assign bus.burst_done = done_q;
  assign dbg_state      = state;

  // Event priority at each edge: reset > abort > burst completion > count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sel_q  <= 3'd0;
      beat_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.dest_en) begin
            sel_q  <= pick_next(sel_q, bus.dest_en, 1'b0);
            beat_q <= '0;
            state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (!cur_en) begin
            // Owner lost its enable: discard the partial burst silently.
            beat_q <= '0;
            if (|bus.dest_en) begin
              sel_q <= pick_next(sel_q, bus.dest_en, 1'b1);
            end else begin
              state <= S_IDLE;
            end
          end else if (xfer && beat_q == LAST) begin
            // dest_en is known nonzero here (the owner bit is set), so the
            // rotation always finds a destination and stays in SEND.
            done_q <= 1'b1;
            beat_q <= '0;
            sel_q  <= pick_next(sel_q, bus.dest_en, 1'b1);
          end else if (xfer) begin
            beat_q <= beat_q + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_1x8_scheduler.sv
// ----------------------------------------------------------------------------
// tb_demux_1x8_scheduler
//
// Directed scenarios for demux_1x8_scheduler (WIDTH=8, BURST=4). The driver
// pushes {expected destination, word} when it presents a word; the monitor
// pops and compares on every observed out_valid strobe.
// ----------------------------------------------------------------------------
module tb_demux_1x8_scheduler;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic clk;
  logic rst_n;
  logic dbg_state;

  demux_1x8_scheduler_if #(.WIDTH(WIDTH), .BURST(BURST)) bus ();

  demux_1x8_scheduler #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int bursts = 0;
  logic [7:0] seen_valid = 8'h00;
  logic [10:0] exp_q[$];  // {dest[2:0], data[7:0]}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst_n) begin
      seen_valid = seen_valid | bus.out_valid;
      if (bus.burst_done) bursts++;
      if (bus.out_valid != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(bus.out_valid), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("route", 32'(bus.out_valid), 32'(8'h01 << e[10:8]));
          check("data", 32'(bus.out_data), 32'(e[7:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; presents a word and records its expected
  // destination.
  task automatic drive_word(input logic [7:0] data, input logic [2:0] dest);
    exp_q.push_back({dest, data});
    bus.in_valid = 1'b1;
    bus.in_data  = data;
  endtask

  // Waits until the pending word is taken; returns just after that edge.
  task automatic wait_accept();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] data, input logic [2:0] dest);
    drive_word(data, dest);
    wait_accept();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] w;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 8'h00;
    bus.dest_en    = 8'h00;
    bus.dest_ready = 8'hFF;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_beat", 32'(bus.beat_cnt), 32'd0);
    check("rst_done", 32'(bus.burst_done), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_ovalid", 32'(bus.out_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // 1) all enabled, all ready, continuous valid
    bus.dest_en = 8'hFF;
    stalls = 0;
    bursts = 0;
    for (int n = 0; n < 32; n++) begin
      w = 8'(n + 8'h10);
      send_word(w, 3'(n / BURST));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rr_sel_wrap", 32'(bus.sel), 32'd0);
    step();
    check("rr_bursts", 32'(bursts), 32'd8);
    check("rr_stalls", 32'(stalls), 32'd1);

    // 2) two destinations 2 and 7
    bus.dest_en = 8'b1000_0100;
    seen_valid = 8'h00;
    for (int n = 0; n < 16; n++) begin
      w = 8'($urandom_range(0, 255));
      send_word(w, ((n / BURST) % 2 == 0) ? 3'd2 : 3'd7);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pair_sel", 32'(bus.sel), 32'd2);
    check("pair_other_bits", 32'(seen_valid & 8'b0111_1011), 32'd0);
    step();

    // 3) dest_ready[0] stalls after word 1
    bus.dest_en = 8'h01;
    bursts = 0;
    send_word(8'hA0, 3'd0);
    send_word(8'hA1, 3'd0);
    bus.dest_ready = 8'hFE;
    drive_word(8'hA2, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_beat", 32'(bus.beat_cnt), 32'd2);
      check("stall_sel", 32'(bus.sel), 32'd0);
      step();
    end
    bus.dest_ready = 8'hFF;
    wait_accept();
    send_word(8'hA3, 3'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_done", 32'(bus.burst_done), 32'd1);
    check("stall_resel", 32'(bus.sel), 32'd0);
    check("stall_beat0", 32'(bus.beat_cnt), 32'd0);
    step();

    // 4) abort: dest_en[0] cleared after 2 words with dest_en=8'h03
    bus.dest_en = 8'h03;
    bursts = 0;
    send_word(8'hB0, 3'd0);
    send_word(8'hB1, 3'd0);
    bus.dest_en  = 8'h02;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("abort_ready_drop", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("abort_sel", 32'(bus.sel), 32'd1);
    check("abort_beat", 32'(bus.beat_cnt), 32'd0);
    check("abort_no_done", 32'(bus.burst_done), 32'd0);
    step();
    check("abort_bursts", 32'(bursts), 32'd0);

    // 5) single destination 5
    bus.dest_en = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("idle_state", 32'(dbg_state), 32'd0);
    step();
    bus.dest_en = 8'h20;
    stalls = 0;
    bursts = 0;
    for (int n = 0; n < 12; n++) begin
      w = 8'($urandom_range(0, 255));
      send_word(w, 3'd5);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("single_sel", 32'(bus.sel), 32'd5);
    step();
    check("single_bursts", 32'(bursts), 32'd3);
    check("single_stalls", 32'(stalls), 32'd1);
    bus.dest_en = 8'h00;
    @(negedge clk);
    check("single_off_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("single_off_state", 32'(dbg_state), 32'd0);
    step();

    // 6) reset mid-burst at sel=3, beat_cnt=2
    bus.dest_en = 8'h08;
    send_word(8'hC0, 3'd3);
    send_word(8'hC1, 3'd3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_sel", 32'(bus.sel), 32'd3);
    check("pre_rst_beat", 32'(bus.beat_cnt), 32'd2);
    step();
    rst_n = 1'b0;
    bus.dest_en = 8'hFF;
    bursts = 0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_sel", 32'(bus.sel), 32'd0);
    check("mid_rst_beat", 32'(bus.beat_cnt), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    check("mid_rst_done", 32'(bus.burst_done), 32'd0);
    step();
    for (int n = 0; n < 4; n++) begin
      send_word(8'(8'hD0 + n), 3'd0);
    end
    bus.in_valid = 1'b0;
    step();
    check("resume_bursts", 32'(bursts), 32'd1);
    step();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x8_scheduler.md
# demux_1x8_scheduler

Round-robin burst scheduler that shares one input word stream among eight destinations by driving the select lines of the 1-to-8 demultiplexer tree. It owns destination selection, per-destination flow control and burst sequencing; the demux itself stays purely combinational downstream of this block. Each destination receives a burst of up to BURST words, then ownership rotates to the next enabled destination.

## Interface
- WIDTH, 8, data word width
- BURST, 4, words per burst before rotating (≥1)
- clk  in  1  rising-edge clock, sole clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  source has a word
- in_data  in  WIDTH  source word
- in_ready  out  1  word accepted this cycle when in_valid && in_ready
- dest_en  in  8  per-destination enable mask, bit k = destination k
- dest_ready  in  8  per-destination ready
- sel  out  3  current destination; ins1 = sel[2], ins2 = sel[1], ins3 = sel[0]; sel=0 → out1, sel=7 → out8
- out_valid  out  8  one-hot strobe to destination sel
- out_data  out  WIDTH  word presented to the demux input
- burst_done  out  1  one-cycle pulse, registered, after the last word of a full burst
- beat_cnt  out  clog2(BURST+1)  words sent in current burst

## Operation
- States: IDLE, SEND.
- IDLE: in_ready=0, out_valid=0. When dest_en≠0, pick the first enabled index searching upward from sel (inclusive), wrapping 7→0. Load sel, clear beat_cnt, enter SEND next cycle.
- SEND: in_ready = dest_en[sel] && dest_ready[sel]. out_valid[sel] = in_valid && in_ready; all other out_valid bits 0. out_data = in_data (pass-through).
- Each transfer increments beat_cnt.
- On the transfer that brings beat_cnt to BURST: next cycle burst_done=1, beat_cnt=0, sel = next enabled index strictly after sel (wrapping). If sel is the only enabled index, it is reselected. If dest_en=0 at that edge → IDLE.
- Stalls (dest_ready[sel]=0 or in_valid=0) hold sel and beat_cnt; no timeout, no preemption.
- dest_en[sel] cleared mid-burst: abort the burst. in_ready drops combinationally the same cycle. Next cycle: beat_cnt=0, sel advances as above, no burst_done. All of dest_en cleared → IDLE.
- Newly enabled destinations join rotation at the next selection point only.
- Priority when events coincide at an edge: reset > abort > burst completion > count increment.

## Timing
- Reset values (clocked with rst_n=0): state IDLE, sel=0, beat_cnt=0, burst_done=0. in_ready=0 and out_valid=0 while in IDLE.
- Data latency 0: in_data → out_data is combinational. out_valid and in_ready are combinational from registered state plus dest_ready/dest_en/in_valid.
- IDLE→SEND takes 1 cycle. The first transfer is possible in the cycle after dest_en becomes nonzero.
- Rotation costs 0 bubble cycles: the cycle after the last beat already presents the new sel.
- Back-to-back throughput is 1 word per cycle while the selected destination stays ready.
- Reset asserted mid-burst: the in-flight burst is discarded. There is no burst_done pulse. sel returns to 0 on the next edge.

## Test plan
- Reset then dest_en=8'hFF, all ready, continuous valid, BURST=4:
  - words 0–3 go to out_valid[0], 4–7 to out_valid[1], and so on; sel returns to 0 after word 31.
  - burst_done pulses 8 times, with no idle cycles.
- dest_en=8'b1000_0100, all ready:
  - sel alternates 2,7,2,7 with 4 words each; out_valid bits 0,1,3–6 never assert.
- dest_ready[0] dropped for 3 cycles after word 1:
  - in_ready=0 for those cycles, beat_cnt holds at 2, sel stays 0.
  - The burst resumes and completes at 4 words.
- dest_en[0] cleared after 2 words with dest_en=8'h03:
  - next cycle sel=1, beat_cnt=0, no burst_done pulse.
- dest_en single bit 8'h20:
  - sel=5 after 1 IDLE cycle and is reselected after every burst, with burst_done each time.
  - Then dest_en=0 → IDLE, in_ready=0.
- rst_n low for 1 cycle mid-burst at sel=3, beat_cnt=2:
  - sel=0, beat_cnt=0, state IDLE, no burst_done.
  - Operation resumes from destination 0.
